ram_window_fetch: RTL
=====================

Name: ram_window_fetch

Overview:
- Parametrised successor to the team's 3x3 window RAM controller: one write port, one multi-tap "window" fetch, and one independent quick-read port.
- A fetch gathers TAPS words in ceil(TAPS/READ_PORTS) cycles over READ_PORTS replicated read banks.
- Out-of-range tap addresses return zero, giving border padding for convolution windows.
- Sits between the feature-map writer and the depthwise/pointwise conv engines of the MobileNet datapath.

Parameters:
- DATA_W, 10, word width.
- ADDR_W, 12, address width.
- DEPTH, 4096, number of words (DEPTH <= 2**ADDR_W).
- TAPS, 9, words returned per fetch.
- READ_PORTS, 1, taps read per cycle (1..TAPS); G = ceil(TAPS/READ_PORTS) fetch cycles.

Ports:
- i_clk  in  1  clock, all activity on rising edge.
- i_reset  in  1  asynchronous, active-high reset.
- i_wrEnable  in  1  write strobe.
- i_addrIn  in  ADDR_W  write address.
- i_data  in  DATA_W  write data.
- i_start  in  1  fetch request; accepted only when o_ready=1.
- i_addrOut  in  TAPS*ADDR_W  tap k address at [k*ADDR_W +: ADDR_W].
- i_quickGet  in  1  quick-read strobe.
- i_addrOutQuick  in  ADDR_W  quick-read address.
- o_data  out  TAPS*DATA_W  tap k word at [k*DATA_W +: DATA_W].
- o_valid  out  1  one-cycle pulse, o_data complete.
- o_ready  out  1  idle, may accept i_start.
- o_quickData  out  DATA_W  registered quick-read result.

Behaviour:
- Reset (async assert, released on a clock edge): o_data=0, o_valid=0, o_ready=0, o_quickData=0, FSM=IDLE, group counter=0. Memory contents are not cleared.
- o_ready rises on the first edge after reset is released.
- Storage: READ_PORTS+1 identical copies. Every write goes to all copies. Bank j serves tap slot j of each group; the extra copy serves only the quick port.
- Write: when i_wrEnable=1 at an edge and i_addrIn<DEPTH, mem[i_addrIn]<=i_data. If i_addrIn>=DEPTH the write is silently dropped. Writes are legal in any FSM state.
- Read-during-write to the same address on the same edge returns the OLD data, on both the fetch and quick ports.
- FSM states:
  - IDLE: o_ready=1. i_start=1 at edge N latches all of i_addrOut, sets o_ready=0, goes to FETCH with g=0. i_start while o_ready=0 is ignored.
  - FETCH: at each edge, bank j reads tap g*READ_PORTS+j (slots beyond TAPS-1 unused) and g increments. After group G-1 is issued, go to DONE.
  - DONE: at the edge the last group's data is captured, o_data is fully written, o_valid=1 for exactly one cycle, o_ready=1, and the FSM returns to IDLE.
- Latency: o_valid high in the cycle after edge N+G+1. Default G=9 gives 10 edges; READ_PORTS=3 gives 4; READ_PORTS=9 gives 2.
- Back-to-back: a new i_start may be sampled on the edge after o_valid rises.
- o_data holds its value until the next fetch completes. Partial updates are never visible: taps are assembled in a shadow register and copied to o_data in a single edge.
- Zero padding: a tap whose latched address is >=DEPTH yields 0 in its slot.
- Quick port: when i_quickGet=1 at an edge, o_quickData<=mem[i_addrOutQuick] (0 if >=DEPTH); otherwise it holds. One-cycle latency, fully independent of the FSM and usable during a fetch.
- Reset mid-fetch: the fetch aborts, no o_valid is produced, and outputs return to their reset values.
- Widths: no arithmetic. Group counter width is clog2(G)+1.

Test Plan:
- Reset, write addr 0..8 with data 0..8, fetch taps (0..8) with defaults -> o_ready low for 10 cycles, single o_valid pulse, o_data slots = 0..8, o_ready=1 in the same cycle.
- Write 10..18 with 20..28, then overwrite 0..8 with 21,12,45,34,46,82,42,11,0 and fetch both windows back-to-back -> {20..28}, then {21,12,45,34,46,82,42,11,0}; second o_valid exactly 10 cycles after second start.
- READ_PORTS=3 build, same fetch -> o_valid 4 edges after start, same data; i_start pulsed while busy is ignored, so exactly one o_valid.
- DEPTH=4000 build, taps {3999,4000,4095,0,...} with mem[3999]=7, mem[0]=5 -> slots 7,0,0,5,...; write to addr 4000 leaves all data unchanged.
- Quick reads of addr 0 then addr 1 on consecutive edges during an active fetch -> o_quickData = 21 then 12 one cycle after each edge; fetch result unaffected. Write addr 1=99 on the same edge as a quick read of addr 1 -> 12, then 99 on the next quick read.
- Assert i_reset at fetch cycle 4 -> o_valid never pulses, o_data=0, o_ready=0 during reset and 1 one edge after release; a new fetch then completes normally.

Source files
------------

// File: rtl/ram_window_fetch.sv
// Window-fetch RAM: one write port, a TAPS-word window fetch spread over
// READ_PORTS replicated banks, and an independent single-word quick-read port.
// Tap addresses at or beyond DEPTH read as zero, which gives border padding.
module ram_window_fetch #(
  parameter int DATA_W     = 10,
  parameter int ADDR_W     = 12,
  parameter int DEPTH      = 4096,
  parameter int TAPS       = 9,
  parameter int READ_PORTS = 1
) (
  input  logic                     i_clk,
  input  logic                     i_reset,
  input  logic                     i_wrEnable,
  input  logic [ADDR_W-1:0]        i_addrIn,
  input  logic [DATA_W-1:0]        i_data,
  input  logic                     i_start,
  input  logic [TAPS*ADDR_W-1:0]   i_addrOut,
  input  logic                     i_quickGet,
  input  logic [ADDR_W-1:0]        i_addrOutQuick,
  output logic [TAPS*DATA_W-1:0]   o_data,
  output logic                     o_valid,
  output logic                     o_ready,
  output logic [DATA_W-1:0]        o_quickData
);

  localparam int G   = (TAPS + READ_PORTS - 1) / READ_PORTS;
  localparam int GW  = $clog2(G) + 1;
  localparam int AW1 = ADDR_W + 1;
  localparam logic [GW-1:0]  G_LAST  = GW'(G - 1);
  localparam logic [AW1-1:0] DEPTH_L = AW1'(DEPTH);

  typedef enum logic [1:0] {IDLE, FETCH, DONE} state_t;

  state_t                     state_q, state_d;
  logic [GW-1:0]              grp_q, grp_d;
  logic [TAPS*ADDR_W-1:0]     taps_q, taps_d;
  logic [TAPS*DATA_W-1:0]     shadow_q, shadow_d;
  logic [READ_PORTS*DATA_W-1:0] rd_q, rd_d;
  logic [TAPS*DATA_W-1:0]     data_q, data_d;
  logic                       valid_q, valid_d;
  logic                       ready_q, ready_d;
  logic [DATA_W-1:0]          quick_q, quick_d;

  // Bank j (j < READ_PORTS) serves tap slot j; the last copy serves the quick port.
  logic [DATA_W-1:0] mem [READ_PORTS+1][DEPTH];

  int                rd_t;
  logic [ADDR_W-1:0] rd_a;
  int                fsm_t;

  function automatic logic in_range(input logic [ADDR_W-1:0] a);
    return {1'b0, a} < DEPTH_L;
  endfunction

  // Every write lands in all copies; out-of-range writes are dropped.
  always_ff @(posedge i_clk) begin
    if (i_wrEnable && in_range(i_addrIn)) begin
      for (int c = 0; c <= READ_PORTS; c++) begin
        mem[c][i_addrIn] <= i_data;
      end
    end
  end

  // Bank reads for the current group and the quick read; memory is sampled
  // before this edge's write lands, so read-during-write returns old data.
  always_comb begin
    rd_d    = rd_q;
    quick_d = quick_q;
    rd_t    = 0;
    rd_a    = '0;
    if (state_q == FETCH) begin
      for (int j = 0; j < READ_PORTS; j++) begin
        rd_t = int'(grp_q) * READ_PORTS + j;
        if (rd_t < TAPS) begin
          rd_a = taps_q[rd_t*ADDR_W +: ADDR_W];
          rd_d[j*DATA_W +: DATA_W] = in_range(rd_a) ? mem[j][rd_a] : '0;
        end
      end
    end
    if (i_quickGet) begin
      quick_d = in_range(i_addrOutQuick) ? mem[READ_PORTS][i_addrOutQuick] : '0;
    end
  end

  // Fetch sequencing: latch taps, issue one group per edge, then publish the
  // assembled window to o_data in a single edge.
  always_comb begin
    state_d  = state_q;
    grp_d    = grp_q;
    taps_d   = taps_q;
    shadow_d = shadow_q;
    data_d   = data_q;
    valid_d  = 1'b0;
    ready_d  = ready_q;
    fsm_t    = 0;
    case (state_q)
      IDLE: begin
        ready_d = 1'b1;
        if (ready_q && i_start) begin
          taps_d  = i_addrOut;
          ready_d = 1'b0;
          grp_d   = '0;
          state_d = FETCH;
        end
      end
      FETCH: begin
        // rd_q holds the previous group's words; park them in the shadow.
        if (grp_q != '0) begin
          for (int j = 0; j < READ_PORTS; j++) begin
            fsm_t = (int'(grp_q) - 1) * READ_PORTS + j;
            if (fsm_t < TAPS) begin
              shadow_d[fsm_t*DATA_W +: DATA_W] = rd_q[j*DATA_W +: DATA_W];
            end
          end
        end
        grp_d = grp_q + 1'b1;
        if (grp_q == G_LAST) begin
          state_d = DONE;
        end
      end
      DONE: begin
        data_d = shadow_q;
        for (int j = 0; j < READ_PORTS; j++) begin
          fsm_t = (G - 1) * READ_PORTS + j;
          if (fsm_t < TAPS) begin
            data_d[fsm_t*DATA_W +: DATA_W] = rd_q[j*DATA_W +: DATA_W];
          end
        end
        valid_d = 1'b1;
        ready_d = 1'b1;
        grp_d   = '0;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Control and visible outputs, cleared by the asynchronous reset.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q <= IDLE;
      grp_q   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ready_q <= 1'b0;
      quick_q <= '0;
    end else begin
      state_q <= state_d;
      grp_q   <= grp_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ready_q <= ready_d;
      quick_q <= quick_d;
    end
  end

  // Internal datapath registers; never observed before the FSM fills them.
  always_ff @(posedge i_clk) begin
    taps_q   <= taps_d;
    shadow_q <= shadow_d;
    rd_q     <= rd_d;
  end

  assign o_data      = data_q;
  assign o_valid     = valid_q;
  assign o_ready     = ready_q;
  assign o_quickData = quick_q;

endmodule
